// File: rtl/band_fetch_pkg.sv
// Shared types and width helpers for the banded BRAM fetch controller.
package band_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // Tag fields are sized for the largest supported image; the top checks that its
    // row/col widths fit and truncates on the way out.
    localparam int unsigned TAG_ROW_W = 16;
    localparam int unsigned TAG_COL_W = 16;

    typedef struct packed {
        logic [TAG_ROW_W-1:0] row;
        logic [TAG_COL_W-1:0] col;
        logic                 last;
    } band_tag_t;

    localparam int unsigned TAG_W = $bits(band_tag_t);

    // Bits needed to index n distinct values (at least 1).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic int unsigned row_width(input int unsigned max_row);
        return idx_width(max_row);
    endfunction

    function automatic int unsigned col_width(input int unsigned max_col);
        return idx_width(max_col);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
module sync_fifo
    import band_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = idx_width(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_wr     = wr_en_i & ~full_o;
    assign do_rd     = rd_en_i & ~empty_o;

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bram_band_fetch.sv
// Fetches a band of consecutive image rows from BRAM and streams tagged pixels out.
// Issue is throttled so that every read in flight always has a FIFO slot waiting.
module bram_band_fetch
    import band_fetch_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_ROW    = 540,
    parameter int unsigned MAX_COL    = 540,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned MAX_BAND   = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ROW_W     = row_width(MAX_ROW),
    localparam int unsigned COL_W     = col_width(MAX_COL),
    localparam int unsigned NR_W      = idx_width(MAX_BAND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ROW_W-1:0]  start_row_i,
    input  logic [NR_W-1:0]   num_rows_i,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] d2mem_o,
    input  logic [DATA_W-1:0] mem2d_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ROW_W-1:0]  out_row_o,
    output logic [COL_W-1:0]  out_col_o,
    output logic              out_last_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned INF_W   = idx_width(RD_LAT + 1);
    localparam int unsigned CNT_W   = idx_width(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_W + TAG_W;

    if (RD_LAT == 0) begin : g_bad_lat
        $error("RD_LAT must be at least 1");
    end
    if (FIFO_DEPTH < RD_LAT + 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least RD_LAT+2");
    end
    if ((64'd1 << ADDR_W) < 64'(MAX_ROW) * 64'(MAX_COL)) begin : g_bad_addr
        $error("ADDR_W too narrow for MAX_ROW*MAX_COL");
    end
    if (ROW_W > TAG_ROW_W || COL_W > TAG_COL_W) begin : g_bad_tag
        $error("image dimensions exceed tag field widths");
    end

    state_e            state_q;
    logic              ena_q, busy_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [NR_W-1:0]   rows_left_q;
    logic [INF_W-1:0]  inflight_q;
    logic              pipe_vld_q [RD_LAT];
    band_tag_t         pipe_tag_q [RD_LAT];

    logic               pop, fifo_wr, fifo_empty, fifo_full, issue_last, credit, row_wrap;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_wr_data, fifo_rd_data;
    band_tag_t          cur_tag, head_tag;
    logic [DATA_W-1:0]  head_data;
    logic [NR_W-1:0]    nr_sat;
    logic [ADDR_W-1:0]  start_addr;
    logic [31:0]        occ;
    logic               unused_bits;

    assign fifo_wr    = pipe_vld_q[RD_LAT-1];
    assign pop        = ~fifo_empty & out_ready_i;
    assign issue_last = (rows_left_q == NR_W'(1)) && (col_q == COL_W'(MAX_COL - 1));
    assign row_wrap   = (row_q == ROW_W'(MAX_ROW - 1));
    assign nr_sat     = (32'(num_rows_i) > MAX_BAND) ? NR_W'(MAX_BAND) : num_rows_i;
    assign start_addr = ADDR_W'(32'(start_row_i) * MAX_COL);

    // Slots committed after this edge: reads in flight, the read being issued now and
    // FIFO contents net of this cycle's pop. A FIFO write moves a beat between the
    // first and last terms, so it cancels out.
    assign occ    = 32'(inflight_q) + 32'(ena_q) + 32'(fifo_count) - 32'(pop);
    assign credit = (occ < FIFO_DEPTH);

    // Tag of the read presented to BRAM this cycle.
    always_comb begin
        cur_tag      = '0;
        cur_tag.row  = TAG_ROW_W'(row_q);
        cur_tag.col  = TAG_COL_W'(col_q);
        cur_tag.last = issue_last;
    end

    // Control FSM with address/row/column walk; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ena_q       <= 1'b0;
            addr_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            rows_left_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (nr_sat == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= StIssue;
                            busy_q      <= 1'b1;
                            ena_q       <= 1'b1;
                            row_q       <= start_row_i;
                            col_q       <= '0;
                            addr_q      <= start_addr;
                            rows_left_q <= nr_sat;
                        end
                    end
                end
                StIssue: begin
                    if (ena_q && issue_last) begin
                        state_q <= StDrain;
                        ena_q   <= 1'b0;
                    end else begin
                        ena_q <= credit;
                        if (ena_q) begin
                            if (col_q == COL_W'(MAX_COL - 1)) begin
                                col_q       <= '0;
                                rows_left_q <= rows_left_q - NR_W'(1);
                                row_q       <= row_wrap ? '0 : row_q + ROW_W'(1);
                                addr_q      <= row_wrap ? '0 : addr_q + ADDR_W'(1);
                            end else begin
                                col_q  <= col_q + COL_W'(1);
                                addr_q <= addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                StDrain: begin
                    // The last-tagged beat is always the final one, so its acceptance
                    // implies the pipeline and FIFO are already empty.
                    if (pop && out_last_o) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Tag pipeline aligned with the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_tag_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= ena_q;
            pipe_tag_q[0] <= cur_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    // Reads issued but not yet written into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            unique case ({ena_q, fifo_wr})
                2'b10:   inflight_q <= inflight_q + INF_W'(1);
                2'b01:   inflight_q <= inflight_q - INF_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign fifo_wr_data = {mem2d_i, pipe_tag_q[RD_LAT-1]};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (out_ready_i),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    assign head_tag  = band_tag_t'(fifo_rd_data[TAG_W-1:0]);
    assign head_data = fifo_rd_data[ENTRY_W-1 -: DATA_W];

    // Outputs are forced to zero when empty so reset leaves no stale FIFO contents visible.
    assign out_valid_o = ~fifo_empty;
    assign out_data_o  = out_valid_o ? head_data : '0;
    assign out_row_o   = out_valid_o ? ROW_W'(head_tag.row) : '0;
    assign out_col_o   = out_valid_o ? COL_W'(head_tag.col) : '0;
    assign out_last_o  = out_valid_o & head_tag.last;

    assign ena_o   = ena_q;
    assign addr_o  = addr_q;
    assign wea_o   = 1'b0;
    assign d2mem_o = '0;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    assign unused_bits = ^{head_tag.row, head_tag.col, fifo_full};

endmodule

// File: tb/tb_bram_band_fetch.sv
// Randomised scoreboard bench for bram_band_fetch against a BRAM and band model.
module tb_bram_band_fetch;

    localparam int DATA_W     = 8;
    localparam int MAX_ROW    = 540;
    localparam int MAX_COL    = 540;
    localparam int ADDR_W     = 19;
    localparam int RD_LAT     = 2;
    localparam int MAX_BAND   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int ROW_W      = $clog2(MAX_ROW);
    localparam int COL_W      = $clog2(MAX_COL);
    localparam int NR_W       = $clog2(MAX_BAND + 1);

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [ROW_W-1:0]  start_row_i;
    logic [NR_W-1:0]   num_rows_i;
    logic              ena_o, wea_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] d2mem_o, mem2d_i, out_data_o;
    logic [ROW_W-1:0]  out_row_o;
    logic [COL_W-1:0]  out_col_o;
    logic              out_last_o, out_valid_o, out_ready_i, busy_o, done_o;

    bram_band_fetch #(
        .DATA_W     (DATA_W),
        .MAX_ROW    (MAX_ROW),
        .MAX_COL    (MAX_COL),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .MAX_BAND   (MAX_BAND),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .start_row_i (start_row_i),
        .num_rows_i  (num_rows_i),
        .ena_o       (ena_o),
        .wea_o       (wea_o),
        .addr_o      (addr_o),
        .d2mem_o     (d2mem_o),
        .mem2d_i     (mem2d_i),
        .out_data_o  (out_data_o),
        .out_row_o   (out_row_o),
        .out_col_o   (out_col_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Image contents as a pure function of address.
    function automatic logic [DATA_W-1:0] mem_val(input int a);
        int h;
        h = a * 37 + (a >> 9) + 90;
        return DATA_W'(h ^ (h >> 8));
    endfunction

    // BRAM: data for an address read in cycle c is on mem2d_i in cycle c+RD_LAT.
    logic [DATA_W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) bram_pipe[i] <= '0;
        end else begin
            if (ena_o) bram_pipe[0] <= mem_val(int'(addr_o));
            for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
        end
    end
    assign mem2d_i = bram_pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Scoreboard: expected addresses and beats (packed data/row/col/last).
    int  exp_addr_q [$];
    int  exp_beat_q [$];
    int  issued = 0, accepted = 0;
    int  done_cnt = 0, done_cyc = -1, done_base = 0;
    int  first_valid_cyc = -1;
    bit  rdy_mode = 0;

    function automatic int pack_beat(input int d, input int r, input int c, input int l);
        return (d << 21) | (r << 11) | (c << 1) | l;
    endfunction

    // Downstream: always ready, or ready roughly 30% of cycles.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready_i = rdy_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: compares BRAM requests and accepted beats against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (ena_o) begin
                issued++;
                if (exp_addr_q.size() == 0) begin
                    check(1'b0, "unexpected_ena", longint'(addr_o), -1);
                end else begin
                    int a;
                    a = exp_addr_q.pop_front();
                    check(int'(addr_o) == a, "addr", longint'(addr_o), a);
                end
                check(issued - accepted <= FIFO_DEPTH, "credit", issued - accepted, FIFO_DEPTH);
            end
            if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = ncyc;
            if (out_valid_o && out_ready_i) begin
                int got;
                accepted++;
                got = pack_beat(int'(out_data_o), int'(out_row_o), int'(out_col_o),
                                int'(out_last_o));
                if (exp_beat_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", got, -1);
                end else begin
                    int e;
                    e = exp_beat_q.pop_front();
                    check(got == e, "beat", got, e);
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = ncyc;
            end
        end
    end

    // Queue the band's expected traffic, pulse start, return the start cycle.
    task automatic start_band(input int sr, input int nr, output int t);
        int n;
        n = (nr > MAX_BAND) ? MAX_BAND : nr;
        for (int r = 0; r < n; r++) begin
            int row;
            row = (sr + r) % MAX_ROW;
            for (int c = 0; c < MAX_COL; c++) begin
                int a;
                a = row * MAX_COL + c;
                exp_addr_q.push_back(a);
                exp_beat_q.push_back(pack_beat(int'(mem_val(a)), row, c,
                                               (r == n - 1 && c == MAX_COL - 1) ? 1 : 0));
            end
        end
        @(posedge clk);
        #1;
        done_base       = done_cnt;
        first_valid_cyc = -1;
        start_row_i     = ROW_W'(sr);
        num_rows_i      = NR_W'(nr);
        start_i         = 1'b1;
        @(negedge clk);
        t = ncyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check(busy_o == (n != 0), "busy_t1", longint'(busy_o), longint'(n != 0));
        check(ena_o == (n != 0), "ena_t1", longint'(ena_o), longint'(n != 0));
    endtask

    // Wait (bounded) for done; optionally poke a start while busy.
    task automatic wait_done(input int t, input int npix, input bit timed, input int poke);
        int i;
        i = 0;
        while (done_cnt == done_base && i < 20000) begin
            @(negedge clk);
            i++;
            if (poke > 0 && i == poke) begin
                start_row_i = ROW_W'(100);
                num_rows_i  = NR_W'(1);
                start_i     = 1'b1;
            end
            if (poke > 0 && i == poke + 1) start_i = 1'b0;
        end
        start_i = 1'b0;
        check(done_cnt == done_base + 1, "done_count", done_cnt - done_base, 1);
        if (npix == 0) begin
            check(done_cyc == t + 1, "done_zero_rows", done_cyc - t, 1);
        end else if (timed) begin
            check(done_cyc == t + 2 + RD_LAT + npix, "done_time", done_cyc - t,
                  2 + RD_LAT + npix);
            check(first_valid_cyc == t + 2 + RD_LAT, "first_valid", first_valid_cyc - t,
                  2 + RD_LAT);
        end
        check(exp_beat_q.size() == 0, "beats_left", exp_beat_q.size(), 0);
        check(exp_addr_q.size() == 0, "addrs_left", exp_addr_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(ena_o == 1'b0, {tag, "_ena"}, longint'(ena_o), 0);
        check(addr_o == '0, {tag, "_addr"}, longint'(addr_o), 0);
        check(out_valid_o == 1'b0, {tag, "_valid"}, longint'(out_valid_o), 0);
        check(out_last_o == 1'b0, {tag, "_last"}, longint'(out_last_o), 0);
        check(out_data_o == '0, {tag, "_data"}, longint'(out_data_o), 0);
        check(out_row_o == '0, {tag, "_row"}, longint'(out_row_o), 0);
        check(out_col_o == '0, {tag, "_col"}, longint'(out_col_o), 0);
        check(busy_o == 1'b0, {tag, "_busy"}, longint'(busy_o), 0);
        check(done_o == 1'b0, {tag, "_done"}, longint'(done_o), 0);
        check(wea_o == 1'b0, {tag, "_wea"}, longint'(wea_o), 0);
        check(d2mem_o == '0, {tag, "_d2mem"}, longint'(d2mem_o), 0);
    endtask

    initial begin
        int t, sr, nr;
        rst         = 1'b1;
        start_i     = 1'b0;
        start_row_i = '0;
        num_rows_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Full band from row 0, then a band wrapping the bottom of the image.
        start_band(0, 3, t);
        wait_done(t, 3 * MAX_COL, 1'b1, 0);
        start_band(MAX_ROW - 1, 2, t);
        wait_done(t, 2 * MAX_COL, 1'b1, 0);

        // Heavy backpressure.
        rdy_mode = 1'b1;
        start_band(17, 3, t);
        wait_done(t, 3 * MAX_COL, 1'b0, 0);
        rdy_mode = 1'b0;

        // Zero-row request.
        start_band(100, 0, t);
        wait_done(t, 0, 1'b1, 0);

        // A start while busy must not disturb the running band.
        start_band(200, 1, t);
        wait_done(t, MAX_COL, 1'b1, 50);

        // Reset in the middle of a band, then a clean restart.
        rdy_mode = 1'b1;
        start_band(5, 2, t);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        issued   = 0;
        accepted = 0;
        @(negedge clk);
        check_idle_outputs("midreset");
        start_band(0, 1, t);
        wait_done(t, MAX_COL, 1'b1, 0);

        // Random single-row or empty bands under random backpressure.
        rdy_mode = 1'b1;
        repeat (4) begin
            sr = $urandom_range(0, MAX_ROW - 1);
            nr = $urandom_range(0, 1);
            start_band(sr, nr, t);
            wait_done(t, nr * MAX_COL, 1'b0, 0);
        end
        rdy_mode = 1'b0;

        check(wea_o == 1'b0, "wea_end", longint'(wea_o), 0);
        check(d2mem_o == '0, "d2mem_end", longint'(d2mem_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
